// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with selectable parity, 1/2 stop bits, error flags and flag-and-clear handshake.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 majority around the bit centre.
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [1:0]            parity_mode,
    input  logic                  rx_flag_clr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_flag,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  overrun,
    output logic                  rx_busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, next_state;
    logic                  rx_meta, rx_sync, rx_prev;
    logic [DIV_WIDTH-1:0]  div_q, bit_cnt, half;
    logic [1:0]            par_mode_q;
    logic [CW-1:0]         data_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  perr_q, ferr_q, done;
    logic                  start_edge, sample_now, sample_bit, par_en, last_stop;

    assign half       = div_q >> 1;
    assign start_edge = (state == IDLE) && rx_prev && !rx_sync;
    assign par_en     = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
    assign rx_busy    = (state != IDLE);

`ifdef UART_RX_MAJORITY_EN
    logic maj_a, maj_b;

    // The first two of the three centre samples; the third is rx_sync at decision time.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else begin
            if (bit_cnt == half - DIV_WIDTH'(1)) maj_a <= rx_sync;
            if (bit_cnt == half)                 maj_b <= rx_sync;
        end
    end

    assign sample_now = (state != IDLE) && (bit_cnt == half + DIV_WIDTH'(1));
    assign sample_bit = (maj_a & maj_b) | (maj_a & rx_sync) | (maj_b & rx_sync);
`else
    assign sample_now = (state != IDLE) && (bit_cnt == half);
    assign sample_bit = rx_sync;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_edge) next_state = START;
            START:   if (sample_now) next_state = sample_bit ? IDLE : DATA;
            DATA:    if (sample_now && data_cnt == CW'(DATA_WIDTH - 1))
                         next_state = par_en ? PARITY : STOP;
            PARITY:  if (sample_now) next_state = STOP;
            STOP:    if (sample_now && last_stop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The bit counter free-runs modulo div from the start edge, so every bit lands on the same phase.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            div_q      <= '0;
            par_mode_q <= '0;
            bit_cnt    <= '0;
            data_cnt   <= '0;
            stop_cnt   <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done       <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            done    <= 1'b0;
            if (start_edge) begin
                div_q      <= (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;
                par_mode_q <= parity_mode;
                bit_cnt    <= '0;
                data_cnt   <= '0;
                stop_cnt   <= 1'b0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
            end else if (state != IDLE) begin
                bit_cnt <= (bit_cnt == div_q - DIV_WIDTH'(1)) ? '0 : bit_cnt + DIV_WIDTH'(1);
                if (sample_now) begin
                    case (state)
                        DATA: begin
                            shift_q  <= {sample_bit, shift_q[DATA_WIDTH-1:1]};
                            data_cnt <= data_cnt + CW'(1);
                        end
                        PARITY: perr_q <= (^shift_q) ^ sample_bit ^ (par_mode_q == 2'b10);
                        STOP: begin
                            if (!sample_bit) ferr_q <= 1'b1;
                            stop_cnt <= stop_cnt + 1'b1;
                            if (last_stop) done <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // A completing frame is dropped if the host has not yet cleared the previous one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data      <= '0;
            rx_flag      <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else if (done) begin
            if (!rx_flag || rx_flag_clr) begin
                rx_data      <= shift_q;
                parity_error <= perr_q;
                frame_error  <= ferr_q;
                rx_flag      <= 1'b1;
                if (rx_flag_clr) overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_flag_clr) begin
            rx_flag      <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end
    end

endmodule
